// File: rtl/arith_pkg.sv
// Shared arithmetic constants and helpers for the borrow-select subtractor.
// Holds the default operand width and the half-width split used by stage 1.
package arith_pkg;

    localparam int WIDTH_DEF = 16;

    function automatic int half_width(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/half_sub.sv
// H-bit subtractor with borrow-in and borrow-out.
// Used for the low half and for both high-half candidates.
module half_sub #(
    parameter int H = 8
) (
    input  logic [H-1:0] a_i,
    input  logic [H-1:0] b_i,
    input  logic         bin_i,
    output logic [H-1:0] d_o,
    output logic         bout_o
);

    logic [H:0] r;

    // one extra bit captures the borrow as the sign of the wide result
    always_comb begin
        r = {1'b0, a_i} - {1'b0, b_i} - {{H{1'b0}}, bin_i};
    end

    assign d_o    = r[H-1:0];
    assign bout_o = r[H];

endmodule

// File: rtl/borrow_sel_subtractor.sv
// Two-stage borrow-select subtractor: diff = a - b, bout = (a < b).
// Optional macro BORROW_SEL_OVF_EN adds a pipelined signed-overflow output ovf.
module borrow_sel_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef BORROW_SEL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int H = half_width(WIDTH);

    logic         adv;
    logic         acc;

    logic [H-1:0] lo_d, hi0_d, hi1_d;
    logic         lb_d, hb0_d, hb1_d;

    logic         s1_valid_q;
    logic [H-1:0] lo_q, hi0_q, hi1_q;
    logic         lb_q, hb0_q, hb1_q;

    logic [H-1:0] sel_hi;
    logic         sel_b;

    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    half_sub #(.H(H)) u_lo (
        .a_i    (a[H-1:0]),
        .b_i    (b[H-1:0]),
        .bin_i  (1'b0),
        .d_o    (lo_d),
        .bout_o (lb_d)
    );

    half_sub #(.H(H)) u_hi0 (
        .a_i    (a[WIDTH-1:H]),
        .b_i    (b[WIDTH-1:H]),
        .bin_i  (1'b0),
        .d_o    (hi0_d),
        .bout_o (hb0_d)
    );

    half_sub #(.H(H)) u_hi1 (
        .a_i    (a[WIDTH-1:H]),
        .b_i    (b[WIDTH-1:H]),
        .bin_i  (1'b1),
        .d_o    (hi1_d),
        .bout_o (hb1_d)
    );

    // output stage can take new data when empty or being drained
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv;
    assign acc      = in_valid && in_ready;

    // low borrow picks the matching high-half candidate
    always_comb begin
        sel_hi = lb_q ? hi1_q : hi0_q;
        sel_b  = lb_q ? hb1_q : hb0_q;
    end

`ifdef BORROW_SEL_OVF_EN
    logic a_msb_q, b_msb_q;
    logic ovf_d, ovf_q;

    // signed overflow: operand signs differ and result sign differs from a
    always_comb begin
        ovf_d = (a_msb_q != b_msb_q) && (sel_hi[H-1] != a_msb_q);
    end
`endif

    // stage 1: register low difference and both high candidates
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
        if (acc) begin
            lo_q  <= lo_d;
            lb_q  <= lb_d;
            hi0_q <= hi0_d;
            hb0_q <= hb0_d;
            hi1_q <= hi1_d;
            hb1_q <= hb1_d;
`ifdef BORROW_SEL_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
        end
    end

    // stage 2: register the selected candidate as the result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
`ifdef BORROW_SEL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q <= {sel_hi, lo_q};
                bout_q <= sel_b;
`ifdef BORROW_SEL_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef BORROW_SEL_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_sel_subtractor.sv
// Self-checking bench for borrow_sel_subtractor (WIDTH=16).
// Scoreboard of expected results plus per-scenario inline checks.
module tb_borrow_sel_subtractor;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] diff;
    logic        bout;
`ifdef BORROW_SEL_OVF_EN
    logic        ovf;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    borrow_sel_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef BORROW_SEL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // scoreboard: mid-cycle view of the handshakes taken at the next edge
    always @(negedge clk) begin
        exp_t e;
        logic o_act;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got diff=%h bout=%b, required no result",
                             diff, bout);
                end else begin
                    e = sb.pop_front();
`ifdef BORROW_SEL_OVF_EN
                    o_act = ovf;
`else
                    o_act = e.o;
`endif
                    if (diff !== e.d || bout !== e.b || o_act !== e.o) begin
                        fails++;
                        $display("FAIL sb_result: got %h/%b/%b, required %h/%b/%b",
                                 diff, bout, o_act, e.d, e.b, e.o);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.d = a - b;
                e.b = (a < b);
                e.o = (a[15] != b[15]) && (e.d[15] != a[15]);
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got v=%b d=%h b=%b, required 0/0000/0",
                     out_valid, diff, bout);
        end
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va[6];
        logic [15:0] vb[6];
        logic [15:0] vd[6];
        logic        vbo[6];
        va  = '{16'h1234, 16'h0100, 16'h0000, 16'hFFFF, 16'h8000, 16'h0005};
        vb  = '{16'h0034, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h0003};
        vd  = '{16'h1200, 16'h00FF, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0002};
        vbo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = va[i];
            b = vb[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_early: got out_valid=%b, required 0", i, out_valid);
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || diff !== vd[i] || bout !== vbo[i]) begin
                fails++;
                $display("FAIL vec%0d_lat2: got v=%b d=%h b=%b, required 1/%h/%b",
                         i, out_valid, diff, bout, vd[i], vbo[i]);
            end
`ifdef BORROW_SEL_OVF_EN
            if (i >= 4) begin
                tests++;
                if (ovf !== (i == 4)) begin
                    fails++;
                    $display("FAIL vec%0d_ovf: got %b, required %b", i, ovf, (i == 4));
                end
            end
`endif
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            in_valid = 1'b1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_in_ready%0d: got %b, required 1", i, in_ready);
            end
            tick();
            if (i >= 1) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_out_valid%0d: got %b, required 1", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_last_valid: got %b, required 1", out_valid);
        end
        tick();
        tests++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got pending=%0d v=%b, required 0/0",
                     sb.size(), out_valid);
        end
    endtask

    task automatic test_stall();
        logic [15:0] held_d;
        logic        held_b;
        logic        acc;
        out_ready = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            if (c == 1) begin
                held_d = diff;
                held_b = bout;
            end
            if (c >= 1) begin
                tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_full%0d: got rdy=%b v=%b, required 0/1",
                             c, in_ready, out_valid);
                end
            end
            if (c >= 2) begin
                tests++;
                if (diff !== held_d || bout !== held_b) begin
                    fails++;
                    $display("FAIL stall_hold%0d: got %h/%b, required %h/%b",
                             c, diff, bout, held_d, held_b);
                end
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        tests++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: got pending=%0d v=%b, required 0/0",
                     sb.size(), out_valid);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_after: got v=%b rdy=%b, required 0/1",
                     out_valid, in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_ghost%0d: got out_valid=%b, required 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/borrow_sel_subtractor.md
BORROW_SEL_SUBTRACTOR -- requirements
Module: borrow_sel_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are even and at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts an operand pair this cycle.
REQ-006 SHALL have ports a and b, inputs, WIDTH each, minuend and subtrahend (unsigned).
REQ-007 SHALL have port out_valid, output, 1, result is valid.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-009 SHALL have port diff, output, WIDTH, difference a - b modulo 2^WIDTH.
REQ-010 SHALL have port bout, output, 1, borrow-out; 1 iff a < b unsigned.

Function
REQ-011 SHALL accept an input when in_valid && in_ready, and deliver a result when out_valid && out_ready.
REQ-012 SHALL split operands at H = WIDTH/2:
- Stage 1 computes the low difference and the low borrow.
- Stage 1 also computes two high-half candidates, one with borrow-in 0 and one with borrow-in 1, each with its own borrow-out.
REQ-013 SHALL have stage 2 register the candidate selected by the stage-1 low borrow, forming diff and bout.
REQ-014 SHALL have a fixed latency of 2 cycles: an operand accepted in cycle N presents its result with out_valid=1 from cycle N+2 when no stall occurs.
REQ-015 SHALL sustain one accepted operand per cycle when out_ready is held at 1.
REQ-016 SHALL drive in_ready = !s1_valid || !out_valid || out_ready.
- The pipeline advances as a whole; there is no skid buffer.
REQ-017 SHALL, when out_valid=1 and out_ready=0, hold diff, bout, out_valid and all stage-1 state stable.
REQ-018 SHALL, on a simultaneous accept and deliver, advance both stages in the same cycle with no loss or duplication.
REQ-019 SHALL keep in_ready combinational only from out_ready and internal state, never from in_valid.
REQ-020 SHALL produce results in acceptance order.
REQ-021 SHALL handle wrap-around: diff equals (a - b) mod 2^WIDTH in all cases.

Reset
REQ-022 SHALL, while rst=1, clear s1_valid and out_valid to 0, and clear diff and bout to 0.
REQ-023 SHALL drop any operands in flight when reset asserts mid-operation; no result from them appears after reset.
REQ-024 SHALL have in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL use macro BORROW_SEL_OVF_EN to control a signed-overflow output.
- Defined: adds output ovf, 1 bit, pipelined with diff. ovf is 1 iff the two's-complement subtraction overflows, i.e. a[MSB] != b[MSB] and diff[MSB] != a[MSB]. ovf resets to 0 and is held under stall like diff.
- Undefined: no ovf port and no related logic.

Structure
REQ-026 SHALL place the WIDTH default and the H = WIDTH/2 split helper in shared package arith_pkg.
REQ-027 SHALL instantiate one sub-module, half_sub (H-bit subtract with borrow-in and borrow-out), three times in stage 1.

Verification
REQ-028 SHALL cover: a=0x1234, b=0x0034 -> diff=0x1200, bout=0, two cycles after accept.
REQ-029 SHALL cover: a=0x0100, b=0x0001 -> diff=0x00FF, bout=0; the low borrow selects the borrow-in-1 high candidate.
REQ-030 SHALL cover: a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1; a=0xFFFF, b=0xFFFF -> diff=0x0000, bout=0.
REQ-031 SHALL cover: 8 back-to-back inputs with out_ready=1 -> 8 in-order results on consecutive cycles. Then out_ready=0 for 5 cycles -> outputs stable, in_ready=0 once both stages are full, with no loss after release.
REQ-032 SHALL cover: rst asserted for 1 cycle with 2 operands in flight -> out_valid=0 next cycle, neither result ever appears, in_ready=1.
REQ-033 SHALL cover, with BORROW_SEL_OVF_EN defined: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1; a=0x0005, b=0x0003 -> diff=0x0002, ovf=0.
